tx_fifo_deserializer: RTL
=========================

Name: tx_fifo_deserializer

Overview:
- Reads the PC-to-radio transmit byte stream from the Tx byte FIFO and reassembles 6-byte frames into 24-bit I and 24-bit Q samples for the DUC/CIC chain.
- Provides one sample per DUC request.
- Primes the FIFO to a start level before it begins consuming.
- On underflow, substitutes zero samples so the DUC is never stalled.
- Flushes the FIFO whenever transmit is stopped.

Parameters:
- FIFO_AW, 12, width of the FIFO read-side used-words count.
- START_LEVEL, 1536, bytes that must be present before sample delivery starts or restarts. Must be >= 6 and < 2^FIFO_AW.

Ports:
- clock  input  1  system clock; all logic rises on this edge.
- reset  input  1  synchronous, active-high.
- run  input  1  transmit enabled; sampled every clock.
- rd_data  input  8  FIFO read data, valid one clock after rd_req (normal, non-show-ahead mode).
- rd_usedw  input  FIFO_AW  FIFO bytes available.
- sample_req  input  1  one-clock pulse from DUC requesting the next sample.
- rd_req  output  1  FIFO read request, one byte per asserted clock.
- fifo_clear  output  1  synchronous FIFO clear, one-clock pulse.
- I_out  output  24  assembled I sample, two's complement.
- Q_out  output  24  assembled Q sample, two's complement.
- sample_valid  output  1  one-clock pulse when I_out/Q_out are updated.
- underflow  output  1  one-clock pulse when a zero sample is substituted.
- req_overrun  output  1  sticky; set when sample_req arrives while a frame read is in progress; cleared only by reset.

Behaviour:
- Reset values: rd_req=0, fifo_clear=1, I_out=0, Q_out=0, sample_valid=0, underflow=0, req_overrun=0, state=CLEAR. A reset mid-read abandons the partial frame; the following CLEAR flushes leftover bytes.
- Byte order on the wire, big-endian: I[23:16], I[15:8], I[7:0], Q[23:16], Q[15:8], Q[7:0].
- CLEAR:
  - fifo_clear=1 for exactly one clock.
  - Next state is WAIT.
- WAIT:
  - fifo_clear=0, rd_req=0.
  - If run=1 and rd_usedw >= START_LEVEL, go to READY.
  - A sample_req here gives I_out=Q_out=0 with sample_valid at the next clock. underflow stays 0, since the block is not yet primed.
- READY:
  - On sample_req with rd_usedw >= 6: go to READ, byte counter=0.
  - On sample_req with rd_usedw < 6: next clock I_out=Q_out=0, sample_valid=1, underflow=1, then go to WAIT to re-prime.
  - If run=0 with no request pending: go to CLEAR.
- READ:
  - rd_req held high for exactly 6 consecutive clocks.
  - Each byte is captured one clock after its request into a 48-bit shift register.
  - I_out/Q_out update together, never partially, on the clock after the 6th byte is captured; sample_valid pulses on that same clock.
  - Latency: sample_req at clock t gives rd_req on t+1..t+6, bytes on t+2..t+7, sample_valid at t+8.
  - After completion: go to READY if run=1, otherwise CLEAR. A run drop mid-frame always finishes the frame first.
- sample_req during READ: request is dropped, req_overrun set, no extra rd_req. DUC request spacing must exceed 8 clocks.
- I_out/Q_out hold their last value between sample_valid pulses. They are forced to 0 on entry to CLEAR.
- rd_usedw is sampled only in WAIT/READY. The 6-byte check guarantees no read of an empty FIFO.

Test Plan:
- Reset, run=1, write 1536 bytes, pulse sample_req: rd_req high 6 clocks; bytes 12 34 56 AB CD EF give I_out=0x123456, Q_out=0xABCDEF; sample_valid at t+8, exactly one pulse.
- run=1 with only 1000 bytes, pulse sample_req: zero sample, sample_valid at t+1, underflow=0, rd_req never asserted. Fill to 1536, request again: normal frame.
- Primed with exactly 10 bytes left: first request reads 6 bytes; second request (4 bytes left) gives zero sample with underflow=1, then state returns to WAIT.
- sample_req pulsed again 3 clocks into a READ: req_overrun=1 and stays set; only 6 rd_req clocks occur; the frame is still correct.
- run dropped at the 3rd rd_req clock: frame completes with valid output, then fifo_clear pulses one clock and I_out=Q_out=0.
- reset asserted mid-READ: rd_req=0 next clock, outputs zero, fifo_clear=1; after release, one fifo_clear pulse then WAIT.

Source files
------------

// File: rtl/tx_fifo_deserializer.sv
// Tx byte FIFO reader: primes to a start level, then reassembles 6-byte
// big-endian frames into 24-bit I/Q samples, one per DUC request.
module tx_fifo_deserializer #(
    parameter int FIFO_AW     = 12,
    parameter int START_LEVEL = 1536
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic [7:0]         rd_data,
    input  logic [FIFO_AW-1:0] rd_usedw,
    input  logic               sample_req,
    output logic               rd_req,
    output logic               fifo_clear,
    output logic [23:0]        I_out,
    output logic [23:0]        Q_out,
    output logic               sample_valid,
    output logic               underflow,
    output logic               req_overrun
);

    typedef enum logic [1:0] {
        CLEAR,
        WAIT,
        READY,
        READ
    } state_t;

    localparam logic [FIFO_AW-1:0] START = FIFO_AW'(START_LEVEL);
    localparam logic [FIFO_AW-1:0] FRAME = FIFO_AW'(6);

    state_t      state;
    state_t      state_n;
    logic        rd_req_n;
    logic [2:0]  req_cnt;
    logic [2:0]  req_cnt_n;
    logic        byte_vld;
    logic [2:0]  byte_cnt;
    logic [2:0]  byte_cnt_n;
    logic [39:0] shift;
    logic [39:0] shift_n;
    logic [47:0] frame;
    logic [23:0] i_n;
    logic [23:0] q_n;
    logic        valid_n;
    logic        uflow_n;
    logic        overrun_n;

    // Final byte joins the shift register on the same edge the sample is published
    assign frame      = {shift, rd_data};
    assign fifo_clear = (state == CLEAR);

    always_comb begin
        state_n    = state;
        rd_req_n   = 1'b0;
        req_cnt_n  = req_cnt;
        byte_cnt_n = byte_cnt;
        shift_n    = shift;
        i_n        = I_out;
        q_n        = Q_out;
        valid_n    = 1'b0;
        uflow_n    = 1'b0;
        overrun_n  = req_overrun;

        if (byte_vld) begin
            shift_n    = {shift[31:0], rd_data};
            byte_cnt_n = byte_cnt + 3'd1;
        end

        unique case (state)
            CLEAR: begin
                state_n = WAIT;
                i_n     = '0;
                q_n     = '0;
            end
            WAIT: begin
                if (sample_req) begin
                    i_n     = '0;
                    q_n     = '0;
                    valid_n = 1'b1;
                end
                if (run && rd_usedw >= START) begin
                    state_n = READY;
                end
            end
            READY: begin
                if (sample_req) begin
                    if (rd_usedw >= FRAME) begin
                        state_n    = READ;
                        rd_req_n   = 1'b1;
                        req_cnt_n  = 3'd0;
                        byte_cnt_n = 3'd0;
                    end else begin
                        state_n = WAIT;
                        i_n     = '0;
                        q_n     = '0;
                        valid_n = 1'b1;
                        uflow_n = 1'b1;
                    end
                end else if (!run) begin
                    state_n = CLEAR;
                    i_n     = '0;
                    q_n     = '0;
                end
            end
            READ: begin
                if (sample_req) begin
                    overrun_n = 1'b1;
                end
                if (rd_req && req_cnt != 3'd5) begin
                    rd_req_n  = 1'b1;
                    req_cnt_n = req_cnt + 3'd1;
                end
                if (byte_vld && byte_cnt == 3'd5) begin
                    i_n     = frame[47:24];
                    q_n     = frame[23:0];
                    valid_n = 1'b1;
                    state_n = run ? READY : CLEAR;
                end
            end
            default: begin
                state_n = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= CLEAR;
            rd_req       <= 1'b0;
            req_cnt      <= '0;
            byte_vld     <= 1'b0;
            byte_cnt     <= '0;
            shift        <= '0;
            I_out        <= '0;
            Q_out        <= '0;
            sample_valid <= 1'b0;
            underflow    <= 1'b0;
            req_overrun  <= 1'b0;
        end else begin
            state        <= state_n;
            rd_req       <= rd_req_n;
            req_cnt      <= req_cnt_n;
            byte_vld     <= rd_req;
            byte_cnt     <= byte_cnt_n;
            shift        <= shift_n;
            I_out        <= i_n;
            Q_out        <= q_n;
            sample_valid <= valid_n;
            underflow    <= uflow_n;
            req_overrun  <= overrun_n;
        end
    end

endmodule
